// File: rtl/ddr3_pll_ctrl.sv
// ddr3_pll_ctrl
//   Bring-up and supervision sequencer for the DDR3 PLL wrapper. It holds the
//   PLL in reset, waits for lock, debounces the synchronized lock and then
//   reports pll_ready. A lock timeout triggers a retry, and an error is raised
//   once all retries are used. Losing lock while ready re-runs the sequence.
//   New loop-filter/charge-pump settings are accepted over a valid/ready
//   handshake.
//
// Ports
//   clk, rst_n                      reference clock, async active-low reset
//   pll_lock                        raw PLL lock (asynchronous to clk)
//   cfg_valid/cfg_ready             settings handshake
//   cfg_icpsel/cfg_lpfres/cfg_lpfcap  requested PLL settings
//   pll_reset                       PLL reset, active high
//   icpsel/lpfres/lpfcap            applied PLL settings
//   pll_ready                       locked and stable
//   pll_error                       all lock attempts exhausted
//   retry_cnt                       failed attempts in the current sequence
module ddr3_pll_ctrl #(
  parameter int unsigned RST_CYCLES     = 1000,
  parameter int unsigned LOCK_TIMEOUT   = 200000,
  parameter int unsigned LOCK_STABLE    = 256,
  parameter int unsigned MAX_RETRY      = 3,
  parameter logic [5:0]  ICP_DEFAULT    = 6'd20,
  parameter logic [2:0]  LPFRES_DEFAULT = 3'd2,
  parameter logic [1:0]  LPFCAP_DEFAULT = 2'd0,
  localparam int unsigned RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          pll_lock,
  input  logic          cfg_valid,
  output logic          cfg_ready,
  input  logic [5:0]    cfg_icpsel,
  input  logic [2:0]    cfg_lpfres,
  input  logic [1:0]    cfg_lpfcap,
  output logic          pll_reset,
  output logic [5:0]    icpsel,
  output logic [2:0]    lpfres,
  output logic [1:0]    lpfcap,
  output logic          pll_ready,
  output logic          pll_error,
  output logic [RW-1:0] retry_cnt
);

  localparam int unsigned MAX_A   = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
  localparam int unsigned MAX_CYC = (MAX_A > LOCK_STABLE) ? MAX_A : LOCK_STABLE;
  localparam int unsigned CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [CW-1:0] RST_LAST    = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] TO_LAST     = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] STABLE_LAST = CW'(LOCK_STABLE - 1);
  localparam logic [RW-1:0] RETRY_MAX   = RW'(MAX_RETRY);

  typedef enum logic [2:0] {
    RESET_HOLD,
    WAIT_LOCK,
    STABLE,
    READY,
    ERROR
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [RW-1:0] retry_cnt_q, retry_cnt_d;
  logic [5:0]    icpsel_q, icpsel_d;
  logic [2:0]    lpfres_q, lpfres_d;
  logic [1:0]    lpfcap_q, lpfcap_d;
  logic          pll_reset_q, pll_reset_d;
  logic          pll_ready_q, pll_ready_d;
  logic          pll_error_q, pll_error_d;
  logic          cfg_ready_q, cfg_ready_d;
  logic          lock_meta_q, lock_meta_d;
  logic          lock_s_q, lock_s_d;
  logic          handshake;

  always_comb begin
    lock_meta_d = pll_lock;
    lock_s_d    = lock_meta_q;
    handshake   = cfg_valid & cfg_ready_q;

    state_d     = state_q;
    retry_cnt_d = retry_cnt_q;
    icpsel_d    = icpsel_q;
    lpfres_d    = lpfres_q;
    lpfcap_d    = lpfcap_q;

    case (state_q)
      RESET_HOLD: begin
        if (cnt_q == RST_LAST) state_d = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        if (lock_s_q) begin
          state_d = STABLE;
        end else if (cnt_q == TO_LAST) begin
          if (retry_cnt_q == RETRY_MAX) begin
            state_d = ERROR;
          end else begin
            retry_cnt_d = retry_cnt_q + 1'b1;
            state_d     = RESET_HOLD;
          end
        end
      end
      STABLE: begin
        if (!lock_s_q) begin
          state_d = WAIT_LOCK;
        end else if (cnt_q == STABLE_LAST) begin
          state_d     = READY;
          retry_cnt_d = '0;
        end
      end
      READY: begin
        // A handshake coinciding with lock loss still latches the new settings.
        if (handshake || !lock_s_q) state_d = RESET_HOLD;
      end
      ERROR: begin
        if (handshake) begin
          retry_cnt_d = '0;
          state_d     = RESET_HOLD;
        end
      end
      default: state_d = RESET_HOLD;
    endcase

    // cfg_ready is only high in READY/ERROR, so a handshake always re-enters reset.
    if (handshake) begin
      icpsel_d = cfg_icpsel;
      lpfres_d = cfg_lpfres;
      lpfcap_d = cfg_lpfcap;
    end

    // Shared counter: cleared on every transition, parked in the untimed states.
    if ((state_d != state_q) || (state_q == READY) || (state_q == ERROR)) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end

    // Outputs are decoded from the next state so they register alongside it.
    pll_reset_d = (state_d == RESET_HOLD) || (state_d == ERROR);
    pll_ready_d = (state_d == READY);
    pll_error_d = (state_d == ERROR);
    cfg_ready_d = (state_d == READY) || (state_d == ERROR);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RESET_HOLD;
      cnt_q       <= '0;
      retry_cnt_q <= '0;
      icpsel_q    <= ICP_DEFAULT;
      lpfres_q    <= LPFRES_DEFAULT;
      lpfcap_q    <= LPFCAP_DEFAULT;
      pll_reset_q <= 1'b1;
      pll_ready_q <= 1'b0;
      pll_error_q <= 1'b0;
      cfg_ready_q <= 1'b0;
      lock_meta_q <= 1'b0;
      lock_s_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      retry_cnt_q <= retry_cnt_d;
      icpsel_q    <= icpsel_d;
      lpfres_q    <= lpfres_d;
      lpfcap_q    <= lpfcap_d;
      pll_reset_q <= pll_reset_d;
      pll_ready_q <= pll_ready_d;
      pll_error_q <= pll_error_d;
      cfg_ready_q <= cfg_ready_d;
      lock_meta_q <= lock_meta_d;
      lock_s_q    <= lock_s_d;
    end
  end

  assign pll_reset = pll_reset_q;
  assign pll_ready = pll_ready_q;
  assign pll_error = pll_error_q;
  assign cfg_ready = cfg_ready_q;
  assign icpsel    = icpsel_q;
  assign lpfres    = lpfres_q;
  assign lpfcap    = lpfcap_q;
  assign retry_cnt = retry_cnt_q;

endmodule
